if_fetch_unit: RTL and testbench

Instruction-fetch stage controller: the producer side of the IF/ID pipeline register. It owns the PC and issues word fetches to instruction memory over a req/ack handshake. It presents `pc_add4_o`/`instruction_o` together with the `hazard_IF_ID_o` hold and `flush_o` bubble controls that the IF/ID register consumes. It sits between instruction memory and IF/ID, and takes stall and redirect inputs from the hazard and branch logic in ID.

---
 rtl/if_fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch controller: owns the PC, runs the imem req/ack handshake and feeds the IF/ID register.
// Optional FETCH_SKID_EN adds a second slot behind the delivery slot so a short stall costs no bubble.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_add4_o,
  output logic [31:0] instruction_o,
  output logic        hazard_IF_ID_o,
  output logic        flush_o
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_disc_addr;
  logic [31:0] w_pc_add4;
  logic        r_s1_vld;
  logic [31:0] r_s1_instr;
  logic [31:0] r_s1_pc4;
  logic        w_consume;
  logic        w_room;
  logic        w_req;
  logic        w_take;
  logic        w_enter_discard;

  assign w_pc_add4 = r_pc + 32'd4;
  assign w_consume = r_s1_vld && !stall_i && !redirect_i;

`ifdef FETCH_SKID_EN
  logic        r_s2_vld;
  logic [31:0] r_s2_instr;
  logic [31:0] r_s2_pc4;

  assign w_room = !(r_s1_vld && r_s2_vld) || w_consume;
`else
  assign w_room = !r_s1_vld || w_consume;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        w_req = w_room;
        // A request already on the bus cannot be withdrawn, so a redirect must wait out its ack
        if (redirect_i)
          w_state_nxt = (w_req && !imem_ack_i) ? ST_DISCARD : ST_FETCH;
        else if (!w_room)
          w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (redirect_i || w_consume)
          w_state_nxt = ST_FETCH;
      end
      ST_DISCARD: begin
        w_req = 1'b1;
        if (imem_ack_i)
          w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  assign w_take          = (r_state == ST_FETCH) && w_req && imem_ack_i && !redirect_i;
  assign w_enter_discard = (r_state == ST_FETCH) && w_req && !imem_ack_i && redirect_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_i)
        r_pc <= redirect_pc_i;
      else if (w_take)
        r_pc <= w_pc_add4;
    end
  end

  // Keeps the abandoned fetch address on the bus while the new PC is already loaded
  always_ff @(posedge clk_i) begin
    if (w_enter_discard)
      r_disc_addr <= r_pc;
  end

`ifdef FETCH_SKID_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_vld   <= 1'b0;
      r_s1_instr <= 32'd0;
      r_s1_pc4   <= 32'd0;
      r_s2_vld   <= 1'b0;
      r_s2_instr <= 32'd0;
      r_s2_pc4   <= 32'd0;
    end else if (redirect_i) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else if (w_consume) begin
      if (r_s2_vld) begin
        r_s1_instr <= r_s2_instr;
        r_s1_pc4   <= r_s2_pc4;
        if (w_take) begin
          r_s2_instr <= imem_rdata_i;
          r_s2_pc4   <= w_pc_add4;
        end else begin
          r_s2_vld <= 1'b0;
        end
      end else if (w_take) begin
        r_s1_instr <= imem_rdata_i;
        r_s1_pc4   <= w_pc_add4;
      end else begin
        r_s1_vld <= 1'b0;
      end
    end else if (w_take) begin
      if (r_s1_vld) begin
        r_s2_vld   <= 1'b1;
        r_s2_instr <= imem_rdata_i;
        r_s2_pc4   <= w_pc_add4;
      end else begin
        r_s1_vld   <= 1'b1;
        r_s1_instr <= imem_rdata_i;
        r_s1_pc4   <= w_pc_add4;
      end
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_vld   <= 1'b0;
      r_s1_instr <= 32'd0;
      r_s1_pc4   <= 32'd0;
    end else if (redirect_i) begin
      r_s1_vld <= 1'b0;
    end else if (w_take) begin
      r_s1_vld   <= 1'b1;
      r_s1_instr <= imem_rdata_i;
      r_s1_pc4   <= w_pc_add4;
    end else if (w_consume) begin
      r_s1_vld <= 1'b0;
    end
  end
`endif

  assign imem_req_o     = !rst_i && w_req;
  assign imem_addr_o    = (r_state == ST_DISCARD) ? r_disc_addr : r_pc;
  assign flush_o        = !rst_i && redirect_i;
  assign hazard_IF_ID_o = rst_i || (!redirect_i && (stall_i || !r_s1_vld));
  assign instruction_o  = r_s1_instr;
  assign pc_add4_o      = r_s1_pc4;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: latency-configurable memory returning rdata=addr, and a scoreboard
// of expected IF/ID captures checked whenever the consumer would latch a real instruction.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] pc4;
  logic [31:0] instr;
  logic        hazard;
  logic        flush;

  logic        wr_rst = 1'b1;
  logic        wr_stall = 1'b0;
  logic        wr_redirect = 1'b0;
  logic [31:0] wr_rpc = 32'd0;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic        wr_ack;
  logic [31:0] wr_rdata;
  logic [31:0] wr_pc4;
  logic [31:0] wr_instr;
  logic        wr_hazard;
  logic        wr_flush;

  int n_cmp  = 0;
  int n_fail = 0;
  int mem_lat = 0;
  int r_wait  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t exp_q[$];

  if_fetch_unit #(.RESET_PC(32'h0000_0100)) u_dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_rdata_i(rdata), .pc_add4_o(pc4),
    .instruction_o(instr), .hazard_IF_ID_o(hazard), .flush_o(flush)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk_i(clk), .rst_i(wr_rst), .stall_i(wr_stall), .redirect_i(wr_redirect),
    .redirect_pc_i(wr_rpc), .imem_req_o(wr_req), .imem_addr_o(wr_addr),
    .imem_ack_i(wr_ack), .imem_rdata_i(wr_rdata), .pc_add4_o(wr_pc4),
    .instruction_o(wr_instr), .hazard_IF_ID_o(wr_hazard), .flush_o(wr_flush)
  );

  // Memory: acks after mem_lat waiting cycles; instruction word equals its address
  assign ack      = req && (r_wait >= mem_lat);
  assign rdata    = addr;
  assign wr_ack   = wr_req;
  assign wr_rdata = wr_addr;

  always @(posedge clk) begin
    if (rst || !req || ack) r_wait <= 0;
    else                    r_wait <= r_wait + 1;
  end

  // IF/ID consumer: a real instruction is captured when not held and not flushed
  always @(negedge clk) begin
    if (!rst && !hazard && !flush) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_capture: got instr=%h pc4=%h want no capture", instr, pc4);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (instr !== e.instr || pc4 !== e.pc4) begin
          n_fail++;
          $display("FAIL capture: got instr=%h pc4=%h want instr=%h pc4=%h", instr, pc4, e.instr, e.pc4);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.instr = a;
    e.pc4   = a + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int lat);
    next_cycle();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; mem_lat = lat;
    next_cycle();
  endtask

  task automatic test_reset();
    next_cycle();
    rst = 1'b1; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h500; mem_lat = 0;
    sample();
    n_cmp++;
    if ({req, hazard, flush} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req=%b hz=%b fl=%b want 0 1 0", req, hazard, flush);
    end
    next_cycle();
    redirect = 1'b0;
    sample();
    n_cmp++;
    if ({instr, pc4} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data: got instr=%h pc4=%h want 0 0", instr, pc4);
    end
    next_cycle();
    rst = 1'b0; stall = 1'b1;
    sample();
    n_cmp++;
    if ({req, addr, hazard, flush} !== {1'b1, 32'h100, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_first_req: got req=%b addr=%h hz=%b fl=%b want 1 00000100 1 0", req, addr, hazard, flush);
    end
    next_cycle();
    sample();
    n_cmp++;
    if ({hazard, instr} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL reset_stall_hold: got hz=%b instr=%h want 1 00000100", hazard, instr);
    end
  endtask

  task automatic test_zero_wait();
    push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
    do_reset(0);
    rst = 1'b0;
    sample();
    n_cmp++;
    if ({req, addr, hazard} !== {1'b1, 32'h100, 1'b1}) begin
      n_fail++;
      $display("FAIL zw_c1: got req=%b addr=%h hz=%b want 1 00000100 1", req, addr, hazard);
    end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = 32'h100 + 32'(4 * i);
      next_cycle();
      sample();
      n_cmp++;
      if ({hazard, instr, pc4, req, addr} !== {1'b0, a, a + 32'd4, 1'b1, a + 32'd4}) begin
        n_fail++;
        $display("FAIL zw_deliver%0d: got hz=%b instr=%h pc4=%h req=%b addr=%h want 0 %h %h 1 %h",
                 i, hazard, instr, pc4, req, addr, a, a + 32'd4, a + 32'd4);
      end
    end
    next_cycle();
    stall = 1'b1;
    sample();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL zw_queue: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
    do_reset(0);
    rst = 1'b0;
    next_cycle();
    next_cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      sample();
      n_cmp++;
      if ({hazard, req, instr, pc4} !== {1'b1, 1'b0, 32'h104, 32'h108}) begin
        n_fail++;
        $display("FAIL stall_frozen%0d: got hz=%b req=%b instr=%h pc4=%h want 1 0 00000104 00000108",
                 i, hazard, req, instr, pc4);
      end
    end
    next_cycle();
    stall = 1'b0;
    sample();
    n_cmp++;
    if ({hazard, instr} !== {1'b0, 32'h104}) begin
      n_fail++;
      $display("FAIL stall_release: got hz=%b instr=%h want 0 00000104", hazard, instr);
    end
    next_cycle();
    sample();
    n_cmp++;
    if ({hazard, req, addr} !== {1'b1, 1'b1, 32'h108}) begin
      n_fail++;
      $display("FAIL stall_refetch: got hz=%b req=%b addr=%h want 1 1 00000108", hazard, req, addr);
    end
    next_cycle();
    sample();
    n_cmp++;
    if ({hazard, instr, pc4} !== {1'b0, 32'h108, 32'h10C}) begin
      n_fail++;
      $display("FAIL stall_next: got hz=%b instr=%h pc4=%h want 0 00000108 0000010c", hazard, instr, pc4);
    end
    next_cycle();
    stall = 1'b1;
    sample();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_queue: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_outstanding();
    push_exp(32'h400);
    do_reset(4);
    rst = 1'b0;
    sample();
    n_cmp++;
    if ({req, addr, hazard} !== {1'b1, 32'h100, 1'b1}) begin
      n_fail++;
      $display("FAIL ro_c1: got req=%b addr=%h hz=%b want 1 00000100 1", req, addr, hazard);
    end
    next_cycle();
    redirect = 1'b1; redirect_pc = 32'h400;
    sample();
    n_cmp++;
    if ({req, addr, hazard, flush} !== {1'b1, 32'h100, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ro_redirect: got req=%b addr=%h hz=%b fl=%b want 1 00000100 0 1", req, addr, hazard, flush);
    end
    next_cycle();
    redirect = 1'b0;
    sample();
    n_cmp++;
    if ({req, addr, flush} !== {1'b1, 32'h100, 1'b0}) begin
      n_fail++;
      $display("FAIL ro_hold1: got req=%b addr=%h fl=%b want 1 00000100 0", req, addr, flush);
    end
    next_cycle();
    sample();
    n_cmp++;
    if ({req, addr, ack} !== {1'b1, 32'h100, 1'b0}) begin
      n_fail++;
      $display("FAIL ro_hold2: got req=%b addr=%h ack=%b want 1 00000100 0", req, addr, ack);
    end
    next_cycle();
    sample();
    n_cmp++;
    if ({req, addr, ack, hazard} !== {1'b1, 32'h100, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ro_ack: got req=%b addr=%h ack=%b hz=%b want 1 00000100 1 1", req, addr, ack, hazard);
    end
    next_cycle();
    mem_lat = 0;
    sample();
    n_cmp++;
    if ({req, addr, hazard} !== {1'b1, 32'h400, 1'b1}) begin
      n_fail++;
      $display("FAIL ro_newreq: got req=%b addr=%h hz=%b want 1 00000400 1", req, addr, hazard);
    end
    next_cycle();
    sample();
    n_cmp++;
    if ({hazard, instr, pc4} !== {1'b0, 32'h400, 32'h404}) begin
      n_fail++;
      $display("FAIL ro_deliver: got hz=%b instr=%h pc4=%h want 0 00000400 00000404", hazard, instr, pc4);
    end
    next_cycle();
    stall = 1'b1;
    sample();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ro_queue: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_stall();
    push_exp(32'h200);
    do_reset(0);
    rst = 1'b0; stall = 1'b1;
    next_cycle();
    sample();
    n_cmp++;
    if ({hazard, req, instr} !== {1'b1, 1'b0, 32'h100}) begin
      n_fail++;
      $display("FAIL rs_full: got hz=%b req=%b instr=%h want 1 0 00000100", hazard, req, instr);
    end
    next_cycle();
    redirect = 1'b1; redirect_pc = 32'h200;
    sample();
    n_cmp++;
    if ({flush, hazard, req} !== 3'b100) begin
      n_fail++;
      $display("FAIL rs_bubble: got fl=%b hz=%b req=%b want 1 0 0", flush, hazard, req);
    end
    next_cycle();
    redirect = 1'b0;
    sample();
    n_cmp++;
    if ({hazard, req, addr, flush} !== {1'b1, 1'b1, 32'h200, 1'b0}) begin
      n_fail++;
      $display("FAIL rs_cleared: got hz=%b req=%b addr=%h fl=%b want 1 1 00000200 0", hazard, req, addr, flush);
    end
    next_cycle();
    stall = 1'b0;
    sample();
    n_cmp++;
    if ({hazard, instr, pc4} !== {1'b0, 32'h200, 32'h204}) begin
      n_fail++;
      $display("FAIL rs_deliver: got hz=%b instr=%h pc4=%h want 0 00000200 00000204", hazard, instr, pc4);
    end
    next_cycle();
    stall = 1'b1;
    sample();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rs_queue: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_pc_wrap();
    next_cycle();
    wr_rst = 1'b0;
    sample();
    n_cmp++;
    if ({wr_req, wr_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_fail++;
      $display("FAIL wrap_req: got req=%b addr=%h want 1 fffffffc", wr_req, wr_addr);
    end
    next_cycle();
    sample();
    n_cmp++;
    if ({wr_hazard, wr_instr, wr_pc4, wr_addr} !== {1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_pc4: got hz=%b instr=%h pc4=%h addr=%h want 0 fffffffc 00000000 00000000",
               wr_hazard, wr_instr, wr_pc4, wr_addr);
    end
    next_cycle();
    sample();
    n_cmp++;
    if ({wr_instr, wr_pc4} !== {32'h0, 32'h4}) begin
      n_fail++;
      $display("FAIL wrap_next: got instr=%h pc4=%h want 00000000 00000004", wr_instr, wr_pc4);
    end
    next_cycle();
    wr_rst = 1'b1;
  endtask

  task automatic test_reset_pending();
    push_exp(32'h100);
    do_reset(4);
    rst = 1'b0;
    sample();
    next_cycle();
    sample();
    n_cmp++;
    if ({req, addr} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL rp_pending: got req=%b addr=%h want 1 00000100", req, addr);
    end
    next_cycle();
    rst = 1'b1;
    sample();
    n_cmp++;
    if ({req, hazard, flush} !== 3'b010) begin
      n_fail++;
      $display("FAIL rp_abandon: got req=%b hz=%b fl=%b want 0 1 0", req, hazard, flush);
    end
    next_cycle();
    mem_lat = 0;
    next_cycle();
    rst = 1'b0;
    sample();
    n_cmp++;
    if ({req, addr, hazard} !== {1'b1, 32'h100, 1'b1}) begin
      n_fail++;
      $display("FAIL rp_restart: got req=%b addr=%h hz=%b want 1 00000100 1", req, addr, hazard);
    end
    next_cycle();
    sample();
    n_cmp++;
    if ({hazard, instr, pc4} !== {1'b0, 32'h100, 32'h104}) begin
      n_fail++;
      $display("FAIL rp_deliver: got hz=%b instr=%h pc4=%h want 0 00000100 00000104", hazard, instr, pc4);
    end
    next_cycle();
    stall = 1'b1;
    sample();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rp_queue: got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_outstanding();
    test_redirect_stall();
    test_pc_wrap();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
